// File: rtl/icache_refill_axi_adapter_if.sv
// Bundles the miss-request, AXI AR/R and line-return signals of the I$ refill adapter.
// The widths must match the parameters of the adapter instance that uses this interface.
interface icache_refill_axi_adapter_if #(
   parameter int unsigned LineWidth    = 128,
   parameter int unsigned AxiDataWidth = 64,
   parameter int unsigned AxiAddrWidth = 64,
   parameter int unsigned AxiIdWidth   = 4,
   parameter int unsigned PlenWidth    = 56,
   parameter int unsigned TidWidth     = 2
);
   logic                    req_valid_i;
   logic                    req_ready_o;
   logic [PlenWidth-1:0]    req_paddr_i;
   logic                    req_nc_i;
   logic [TidWidth-1:0]     req_tid_i;

   logic                    ar_valid_o;
   logic                    ar_ready_i;
   logic [AxiAddrWidth-1:0] ar_addr_o;
   logic [7:0]              ar_len_o;
   logic [2:0]              ar_size_o;
   logic [1:0]              ar_burst_o;
   logic [AxiIdWidth-1:0]   ar_id_o;

   logic                    r_valid_i;
   logic                    r_ready_o;
   logic [AxiDataWidth-1:0] r_data_i;
   logic [1:0]              r_resp_i;
   logic                    r_last_i;

   logic                    rtrn_valid_o;
   logic                    rtrn_ready_i;
   logic [LineWidth-1:0]    rtrn_data_o;
   logic [TidWidth-1:0]     rtrn_tid_o;
   logic                    rtrn_nc_o;
   logic                    rtrn_err_o;

   // Adapter side.
   modport master (
      input  req_valid_i, req_paddr_i, req_nc_i, req_tid_i,
      input  ar_ready_i,
      input  r_valid_i, r_data_i, r_resp_i, r_last_i,
      input  rtrn_ready_i,
      output req_ready_o,
      output ar_valid_o, ar_addr_o, ar_len_o, ar_size_o, ar_burst_o, ar_id_o,
      output r_ready_o,
      output rtrn_valid_o, rtrn_data_o, rtrn_tid_o, rtrn_nc_o, rtrn_err_o
   );

   // Cache / interconnect side.
   modport slave (
      output req_valid_i, req_paddr_i, req_nc_i, req_tid_i,
      output ar_ready_i,
      output r_valid_i, r_data_i, r_resp_i, r_last_i,
      output rtrn_ready_i,
      input  req_ready_o,
      input  ar_valid_o, ar_addr_o, ar_len_o, ar_size_o, ar_burst_o, ar_id_o,
      input  r_ready_o,
      input  rtrn_valid_o, rtrn_data_o, rtrn_tid_o, rtrn_nc_o, rtrn_err_o
   );
endinterface

// File: rtl/icache_refill_axi_adapter.sv
// I$ refill engine: turns miss requests into AXI AR bursts and assembles R beats into lines.
// Define ICACHE_REFILL_ERR_EN to report bus errors (r_resp[1]) on rtrn_err_o.
module icache_refill_axi_adapter #(
   parameter int unsigned LineWidth      = 128,
   parameter int unsigned AxiDataWidth   = 64,
   parameter int unsigned AxiAddrWidth   = 64,
   parameter int unsigned AxiIdWidth     = 4,
   parameter int unsigned AxiId          = 0,
   parameter int unsigned PlenWidth      = 56,
   parameter int unsigned TidWidth       = 2,
   parameter int unsigned MaxOutstanding = 2
) (
   input logic                          clk_i,
   input logic                          rst_ni,
   icache_refill_axi_adapter_if.master  bus
);
   localparam int unsigned Beats     = LineWidth / AxiDataWidth;
   localparam int unsigned BcntWidth = (Beats > 1) ? $clog2(Beats) : 1;
   localparam int unsigned CntWidth  = $clog2(MaxOutstanding + 1);
   localparam int unsigned PtrWidth  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
   localparam int unsigned LineBytes = LineWidth / 8;
   localparam int unsigned BeatBytes = AxiDataWidth / 8;
   localparam int unsigned AxSize    = $clog2(BeatBytes);

   localparam logic [PlenWidth-1:0] LineMask = ~PlenWidth'(LineBytes - 1);
   localparam logic [PlenWidth-1:0] BeatMask = ~PlenWidth'(BeatBytes - 1);

   if ((Beats == 0) || (Beats > 256) || ((Beats & (Beats - 1)) != 0)) begin : g_bad_ratio
      $error("LineWidth/AxiDataWidth must be a power of two no larger than 256");
   end

   typedef struct packed {
      logic [TidWidth-1:0] tid;
      logic                nc;
   } pend_t;

   pend_t                   fifo_q [MaxOutstanding];
   logic [PtrWidth-1:0]     wptr_q, rptr_q;
   logic [CntWidth-1:0]     pend_cnt_q;
   logic [BcntWidth-1:0]    bcnt_q;
   logic [LineWidth-1:0]    line_q;

   logic                    ar_valid_q;
   logic [AxiAddrWidth-1:0] ar_addr_q;
   logic [7:0]              ar_len_q;
   logic [2:0]              ar_size_q;
   logic [1:0]              ar_burst_q;
   logic [AxiIdWidth-1:0]   ar_id_q;

   logic                    rtrn_valid_q;
   logic [TidWidth-1:0]     rtrn_tid_q;
   logic                    rtrn_nc_q;

   logic  req_hs, ar_hs, r_hs, rtrn_hs, beat_ok;
   pend_t front;

   function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
      return (p == PtrWidth'(MaxOutstanding - 1)) ? '0 : p + PtrWidth'(1);
   endfunction

   assign bus.req_ready_o = !ar_valid_q && (pend_cnt_q < CntWidth'(MaxOutstanding));
   assign bus.r_ready_o   = !rtrn_valid_q;

   assign req_hs  = bus.req_valid_i && bus.req_ready_o;
   assign ar_hs   = ar_valid_q && bus.ar_ready_i;
   assign r_hs    = bus.r_valid_i && bus.r_ready_o;
   assign rtrn_hs = rtrn_valid_q && bus.rtrn_ready_i;
   // Beats arriving with nothing pending are swallowed without touching the buffer.
   assign beat_ok = r_hs && (pend_cnt_q != '0);
   assign front   = fifo_q[rptr_q];

   assign bus.ar_valid_o   = ar_valid_q;
   assign bus.ar_addr_o    = ar_addr_q;
   assign bus.ar_len_o     = ar_len_q;
   assign bus.ar_size_o    = ar_size_q;
   assign bus.ar_burst_o   = ar_burst_q;
   assign bus.ar_id_o      = ar_id_q;
   assign bus.rtrn_valid_o = rtrn_valid_q;
   assign bus.rtrn_data_o  = line_q;
   assign bus.rtrn_tid_o   = rtrn_tid_q;
   assign bus.rtrn_nc_o    = rtrn_nc_q;

   // Request acceptance, AR register and pending tag FIFO.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(MaxOutstanding); i++) fifo_q[i] <= '0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         pend_cnt_q <= '0;
         ar_valid_q <= 1'b0;
         ar_addr_q  <= '0;
         ar_len_q   <= '0;
         ar_size_q  <= '0;
         ar_burst_q <= '0;
         ar_id_q    <= '0;
      end else begin
         if (req_hs) begin
            fifo_q[wptr_q] <= '{tid: bus.req_tid_i, nc: bus.req_nc_i};
            wptr_q         <= ptr_inc(wptr_q);
            ar_valid_q     <= 1'b1;
            ar_addr_q      <= AxiAddrWidth'(bus.req_paddr_i & (bus.req_nc_i ? BeatMask : LineMask));
            ar_len_q       <= bus.req_nc_i ? 8'd0 : 8'(Beats - 1);
            ar_size_q      <= 3'(AxSize);
            ar_burst_q     <= 2'b01;
            ar_id_q        <= AxiIdWidth'(AxiId);
         end else if (ar_hs) begin
            ar_valid_q <= 1'b0;
         end
         if (rtrn_hs) rptr_q <= ptr_inc(rptr_q);
         case ({req_hs, rtrn_hs})
            2'b10:   pend_cnt_q <= pend_cnt_q + CntWidth'(1);
            2'b01:   pend_cnt_q <= pend_cnt_q - CntWidth'(1);
            default: pend_cnt_q <= pend_cnt_q;
         endcase
      end
   end

   // Beat assembly into the single line buffer and line return.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         bcnt_q       <= '0;
         line_q       <= '0;
         rtrn_valid_q <= 1'b0;
         rtrn_tid_q   <= '0;
         rtrn_nc_q    <= 1'b0;
      end else if (beat_ok) begin
         if (front.nc) line_q <= LineWidth'(bus.r_data_i);
         else          line_q[bcnt_q*AxiDataWidth +: AxiDataWidth] <= bus.r_data_i;
         if (bus.r_last_i) begin
            bcnt_q       <= '0;
            rtrn_valid_q <= 1'b1;
            rtrn_tid_q   <= front.tid;
            rtrn_nc_q    <= front.nc;
         end else if (Beats > 1) begin
            bcnt_q <= bcnt_q + BcntWidth'(1);
         end
      end else if (rtrn_hs) begin
         rtrn_valid_q <= 1'b0;
      end
   end

`ifdef ICACHE_REFILL_ERR_EN
   logic err_acc_q, rtrn_err_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_acc_q  <= 1'b0;
         rtrn_err_q <= 1'b0;
      end else if (beat_ok) begin
         if (bus.r_last_i) begin
            rtrn_err_q <= err_acc_q | bus.r_resp_i[1];
            err_acc_q  <= 1'b0;
         end else begin
            err_acc_q  <= err_acc_q | bus.r_resp_i[1];
         end
      end
   end

   assign bus.rtrn_err_o = rtrn_err_q;
`else
   logic unused_resp;
   assign unused_resp    = ^bus.r_resp_i;
   assign bus.rtrn_err_o = 1'b0;
`endif

   a_early_last: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (beat_ok && bus.r_last_i && !front.nc) |-> (bcnt_q == BcntWidth'(Beats - 1)));

   a_orphan_beat: assert property (@(posedge clk_i) disable iff (!rst_ni)
      r_hs |-> (pend_cnt_q != '0));
endmodule

// File: tb/tb_icache_refill_axi_adapter.sv
// Scoreboard bench for icache_refill_axi_adapter (default widths: 128-bit line, 64-bit beats).
module tb_icache_refill_axi_adapter;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

`ifdef ICACHE_REFILL_ERR_EN
   localparam logic ErrEn = 1'b1;
`else
   localparam logic ErrEn = 1'b0;
`endif

   icache_refill_axi_adapter_if bus ();

   icache_refill_axi_adapter dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   typedef struct packed {
      logic [63:0] addr;
      logic [7:0]  len;
   } ar_exp_t;

   typedef struct packed {
      logic [127:0] data;
      logic [1:0]   tid;
      logic         nc;
      logic         err;
   } rt_exp_t;

   ar_exp_t ar_q[$];
   rt_exp_t rt_q[$];
   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic flag(input string name, input string what);
      tests++;
      fails++;
      $display("FAIL %s: %s", name, what);
   endtask

   // AR monitor: every handshake must match the oldest expected AR.
   always @(negedge clk) begin
      ar_exp_t e;
      if (rst_n && bus.ar_valid_o && bus.ar_ready_i) begin
         if (ar_q.size() == 0) flag("ar_unexpected", "AR handshake with no expected request");
         else begin
            e = ar_q.pop_front();
            chk("ar_addr", bus.ar_addr_o, e.addr);
            chk("ar_len", bus.ar_len_o, e.len);
            chk("ar_size", bus.ar_size_o, 3);
            chk("ar_burst", bus.ar_burst_o, 1);
            chk("ar_id", bus.ar_id_o, 0);
         end
      end
   end

   // Return monitor: every line handshake must match the oldest expected line.
   always @(negedge clk) begin
      rt_exp_t e;
      if (rst_n && bus.rtrn_valid_o && bus.rtrn_ready_i) begin
         if (rt_q.size() == 0) flag("rtrn_unexpected", "line returned with none expected");
         else begin
            e = rt_q.pop_front();
            chk("rtrn_data", bus.rtrn_data_o, e.data);
            chk("rtrn_tid", bus.rtrn_tid_o, e.tid);
            chk("rtrn_nc", bus.rtrn_nc_o, e.nc);
            chk("rtrn_err", bus.rtrn_err_o, e.err);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic do_req(input logic [55:0] pa, input logic nc, input logic [1:0] tid,
                         input logic [63:0] exp_addr, input logic [7:0] exp_len);
      int n = 0;
      while (!bus.req_ready_o && n < 50) begin @(posedge clk); #1; n++; end
      if (!bus.req_ready_o) begin
         flag("req_ready_wait", "req_ready_o stayed 0, required 1");
         return;
      end
      ar_q.push_back('{addr: exp_addr, len: exp_len});
      bus.req_valid_i = 1'b1;
      bus.req_paddr_i = pa;
      bus.req_nc_i    = nc;
      bus.req_tid_i   = tid;
      @(posedge clk); #1;
      bus.req_valid_i = 1'b0;
      chk("ar_valid_latency", bus.ar_valid_o, 1);
   endtask

   task automatic send_beat(input logic [63:0] d, input logic [1:0] resp, input logic last);
      int n = 0;
      bus.r_valid_i = 1'b1;
      bus.r_data_i  = d;
      bus.r_resp_i  = resp;
      bus.r_last_i  = last;
      while (!bus.r_ready_o && n < 50) begin @(posedge clk); #1; n++; end
      if (!bus.r_ready_o) begin
         flag("r_ready_wait", "r_ready_o stayed 0, required 1");
      end else begin
         @(posedge clk); #1;
      end
      bus.r_valid_i = 1'b0;
      bus.r_last_i  = 1'b0;
      bus.r_resp_i  = 2'b00;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_req_ready"}, bus.req_ready_o, 1);
      chk({tag, "_r_ready"}, bus.r_ready_o, 1);
      chk({tag, "_ar_valid"}, bus.ar_valid_o, 0);
      chk({tag, "_rtrn_valid"}, bus.rtrn_valid_o, 0);
      chk({tag, "_ar_fields"}, {bus.ar_addr_o, bus.ar_len_o, bus.ar_size_o, bus.ar_burst_o, bus.ar_id_o}, 0);
      chk({tag, "_rtrn_fields"}, {bus.rtrn_tid_o, bus.rtrn_nc_o, bus.rtrn_err_o}, 0);
      chk({tag, "_rtrn_data"}, bus.rtrn_data_o, 0);
   endtask

   initial begin
      rst_n            = 1'b0;
      bus.req_valid_i  = 1'b0;
      bus.req_paddr_i  = '0;
      bus.req_nc_i     = 1'b0;
      bus.req_tid_i    = '0;
      bus.ar_ready_i   = 1'b1;
      bus.r_valid_i    = 1'b0;
      bus.r_data_i     = '0;
      bus.r_resp_i     = '0;
      bus.r_last_i     = 1'b0;
      bus.rtrn_ready_i = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs("rst");
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Cacheable line: 0x8000_0014 -> 0x8000_0010, two beats assembled {B,A}.
      do_req(56'h0000_8000_0014, 1'b0, 2'd1, 64'h8000_0010, 8'd1);
      send_beat(64'hAAAA_0000_0000_0001, 2'b00, 1'b0);
      rt_q.push_back('{data: {64'hBBBB_0000_0000_0002, 64'hAAAA_0000_0000_0001}, tid: 2'd1, nc: 1'b0, err: 1'b0});
      send_beat(64'hBBBB_0000_0000_0002, 2'b00, 1'b1);
      chk("rtrn_valid_latency", bus.rtrn_valid_o, 1);
      @(posedge clk); #1;
      chk("rtrn_valid_drop", bus.rtrn_valid_o, 0);

      // Non-cacheable fetch with AR held off for three cycles.
      bus.ar_ready_i = 1'b0;
      do_req(56'h1004, 1'b1, 2'd2, 64'h1000, 8'd0);
      for (int i = 0; i < 3; i++) begin
         chk("ar_hold_valid", bus.ar_valid_o, 1);
         chk("ar_hold_addr", bus.ar_addr_o, 64'h1000);
         chk("ar_hold_req_ready", bus.req_ready_o, 0);
         @(posedge clk); #1;
      end
      bus.ar_ready_i = 1'b1;
      @(posedge clk); #1;
      chk("ar_valid_drop", bus.ar_valid_o, 0);
      rt_q.push_back('{data: {64'h0, 64'hDDDD_0000_0000_0004}, tid: 2'd2, nc: 1'b1, err: 1'b0});
      send_beat(64'hDDDD_0000_0000_0004, 2'b00, 1'b1);
      @(posedge clk); #1;

      // Outstanding limit: tids 0,1 fill the FIFO, tid 2 waits for tid 0's return.
      do_req(56'h4000, 1'b0, 2'd0, 64'h4000, 8'd1);
      do_req(56'h4020, 1'b0, 2'd1, 64'h4020, 8'd1);
      @(posedge clk); #1;
      chk("full_req_ready_0", bus.req_ready_o, 0);
      @(posedge clk); #1;
      chk("full_req_ready_1", bus.req_ready_o, 0);
      rt_q.push_back('{data: {64'h0A0A_0000_0000_0011, 64'h0A0A_0000_0000_0010}, tid: 2'd0, nc: 1'b0, err: 1'b0});
      send_beat(64'h0A0A_0000_0000_0010, 2'b00, 1'b0);
      send_beat(64'h0A0A_0000_0000_0011, 2'b00, 1'b1);
      chk("full_req_ready_ret", bus.req_ready_o, 0);
      @(posedge clk); #1;
      chk("req_ready_after_pop", bus.req_ready_o, 1);
      do_req(56'h4048, 1'b0, 2'd2, 64'h4040, 8'd1);

      // Return stall for five cycles with the next beat already waiting.
      bus.rtrn_ready_i = 1'b0;
      rt_q.push_back('{data: {64'h0B0B_0000_0000_0021, 64'h0B0B_0000_0000_0020}, tid: 2'd1, nc: 1'b0, err: 1'b0});
      send_beat(64'h0B0B_0000_0000_0020, 2'b00, 1'b0);
      send_beat(64'h0B0B_0000_0000_0021, 2'b00, 1'b1);
      bus.r_valid_i = 1'b1;
      bus.r_data_i  = 64'h0C0C_0000_0000_0030;
      for (int i = 0; i < 5; i++) begin
         chk("stall_r_ready", bus.r_ready_o, 0);
         chk("stall_rtrn_valid", bus.rtrn_valid_o, 1);
         chk("stall_rtrn_data", bus.rtrn_data_o, {64'h0B0B_0000_0000_0021, 64'h0B0B_0000_0000_0020});
         chk("stall_rtrn_tid", {bus.rtrn_tid_o, bus.rtrn_nc_o}, {2'd1, 1'b0});
         @(posedge clk); #1;
      end
      bus.rtrn_ready_i = 1'b1;
      @(posedge clk); #1;
      chk("r_ready_after_rtrn", bus.r_ready_o, 1);
      send_beat(64'h0C0C_0000_0000_0030, 2'b00, 1'b0);
      rt_q.push_back('{data: {64'h0C0C_0000_0000_0031, 64'h0C0C_0000_0000_0030}, tid: 2'd2, nc: 1'b0, err: 1'b0});
      send_beat(64'h0C0C_0000_0000_0031, 2'b00, 1'b1);
      @(posedge clk); #1;

      // SLVERR on the second beat, then a clean line.
      do_req(56'h2000_004C, 1'b0, 2'd3, 64'h2000_0040, 8'd1);
      send_beat(64'hE0E0_0000_0000_0040, 2'b00, 1'b0);
      rt_q.push_back('{data: {64'hE0E0_0000_0000_0041, 64'hE0E0_0000_0000_0040}, tid: 2'd3, nc: 1'b0, err: ErrEn});
      send_beat(64'hE0E0_0000_0000_0041, 2'b10, 1'b1);
      do_req(56'h5008, 1'b0, 2'd0, 64'h5000, 8'd1);
      send_beat(64'hF0F0_0000_0000_0050, 2'b00, 1'b0);
      rt_q.push_back('{data: {64'hF0F0_0000_0000_0051, 64'hF0F0_0000_0000_0050}, tid: 2'd0, nc: 1'b0, err: 1'b0});
      send_beat(64'hF0F0_0000_0000_0051, 2'b00, 1'b1);
      @(posedge clk); #1;

      // Reset between the beats of a burst.
      do_req(56'h3000, 1'b0, 2'd1, 64'h3000, 8'd1);
      send_beat(64'h6060_0000_0000_0060, 2'b00, 1'b0);
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("midrst");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("midrst_pend_cnt", dut.pend_cnt_q, 0);
      chk("midrst_bcnt", dut.bcnt_q, 0);
      do_req(56'h601C, 1'b0, 2'd2, 64'h6010, 8'd1);
      send_beat(64'h7070_0000_0000_0070, 2'b00, 1'b0);
      rt_q.push_back('{data: {64'h7070_0000_0000_0071, 64'h7070_0000_0000_0070}, tid: 2'd2, nc: 1'b0, err: 1'b0});
      send_beat(64'h7070_0000_0000_0071, 2'b00, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      chk("ar_q_drained", ar_q.size(), 0);
      chk("rt_q_drained", rt_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/icache_refill_axi_adapter.md
# icache_refill_axi_adapter

Refill engine between the L1 instruction cache miss port and a parametric-width AXI read channel. It converts cache-line and non-cacheable fetch requests into AXI AR bursts, assembles the R beats into full lines, and returns them to the cache through a valid/ready handshake. Compared with the fixed 64-bit single-request wrapper it replaces, it adds:
- configurable bus-to-line width ratio;
- up to `MaxOutstanding` in-flight refills;
- return backpressure;
- optional bus-error reporting.

## Interface
Parameters:
- `LineWidth`, 128: I$ line width in bits.
- `AxiDataWidth`, 64: R data width. `LineWidth/AxiDataWidth` must be a power of two, at most 256.
- `AxiAddrWidth`, 64: AR address width.
- `AxiIdWidth`, 4: AXI ID width.
- `AxiId`, 0: constant ID driven on every AR.
- `PlenWidth`, 56: physical address width, at most `AxiAddrWidth`.
- `TidWidth`, 2: cache transaction tag width.
- `MaxOutstanding`, 2: in-flight request limit, at least 1.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `req_valid_i` / `req_ready_o`  in/out  1  miss-request handshake.
- `req_paddr_i`  in  PlenWidth  fetch physical address.
- `req_nc_i`  in  1  non-cacheable (single-beat) fetch.
- `req_tid_i`  in  TidWidth  request tag.
- `ar_valid_o` / `ar_ready_i`  out/in  1  AR handshake.
- `ar_addr_o`  out  AxiAddrWidth.
- `ar_len_o`  out  8.
- `ar_size_o`  out  3.
- `ar_burst_o`  out  2.
- `ar_id_o`  out  AxiIdWidth.
- `r_valid_i` / `r_ready_o`  in/out  1  R handshake.
- `r_data_i`  in  AxiDataWidth.
- `r_resp_i`  in  2.
- `r_last_i`  in  1.
- `rtrn_valid_o` / `rtrn_ready_i`  out/in  1  line-return handshake.
- `rtrn_data_o`  out  LineWidth  assembled line.
- `rtrn_tid_o`  out  TidWidth  tag of the returned line.
- `rtrn_nc_o`  out  1  return is a non-cacheable fetch.
- `rtrn_err_o`  out  1  bus error seen on any beat (see Configuration).

## Operation
Constants: `Beats = LineWidth/AxiDataWidth`.

Request side:
- `req_ready_o = !ar_valid_o && (pend_cnt < MaxOutstanding)`.
- On acceptance, {tid, nc} are pushed into the pending FIFO (depth `MaxOutstanding`) and the AR register is loaded.

AR field values:
- Cacheable fetch:
  - address = `paddr` aligned down to a line boundary;
  - `ar_len_o = Beats-1`;
  - `ar_burst_o = INCR`.
- Non-cacheable fetch:
  - address = `paddr` aligned down to `AxiDataWidth/8` bytes;
  - `ar_len_o = 0`.
- Both: `ar_size_o = log2(AxiDataWidth/8)`, `ar_id_o = AxiId`, upper address bits zero-extended.

AR channel:
- `ar_valid_o` holds, with all AR fields stable, until `ar_ready_i` is seen.

Beat assembly (AXI ordering with a single ID keeps R in request order):
- The beat counter `bcnt` writes beat `bcnt` into line slice `bcnt`.
- A non-cacheable beat goes to slice 0; all other slices are zero.
- `r_ready_o = !rtrn_valid_o`. There is a single assembly/return buffer.

Line completion:
- Completion is on `r_last_i`. It sets `rtrn_valid_o`, clears `bcnt`, and presents the front FIFO entry on `rtrn_tid_o` and `rtrn_nc_o`.

Return and pending count:
- A return handshake pops the FIFO and decrements `pend_cnt`.
- `pend_cnt` increments on request acceptance.
- Increment and decrement in the same cycle leave `pend_cnt` unchanged.

Boundary behaviour:
- `r_last_i` before the expected beat count: the line completes with the remaining slices holding stale data. An assertion flags this.
- `r_valid_i` with an empty pending FIFO: the beat is consumed and discarded. An assertion flags this.
- Reset mid-operation clears the FIFO, counters and buffer. Transactions already issued are abandoned; system reset covers the interconnect.

## Timing
Reset values of outputs:
- `req_ready_o` = 1, `r_ready_o` = 1.
- `ar_valid_o` = 0, `rtrn_valid_o` = 0.
- All data, tag and AR fields = 0.

Latencies:
- Request accepted in cycle t: `ar_valid_o` rises at t+1.
- The earliest next request acceptance is the cycle after the AR handshake.
- Last R beat in cycle t: `rtrn_valid_o` at t+1 (registered).
- `rtrn_valid_o` and all `rtrn_*` fields hold until `rtrn_ready_i` is seen.
- While the return is stalled, `r_ready_o` = 0.
- After the return handshake in cycle t, `r_ready_o` = 1 at t+1.

Throughput:
- Full bus rate when `rtrn_ready_i` is tied high, plus one bubble per line.

## Configuration
Macro: `ICACHE_REFILL_ERR_EN`.
- Defined:
  - `rtrn_err_o` = OR of `r_resp_i[1]` over all beats of the line;
  - the accumulator is cleared when a line completes.
- Undefined:
  - `rtrn_err_o` is tied to 0;
  - `r_resp_i` is ignored, with no error register.

## Test plan
- Reset, then one cacheable request with `paddr=0x8000_0014`, `tid=1`, `Beats=2` -> AR `addr=0x8000_0010`, `len=1`. Beats A then B -> `rtrn_data_o={B,A}`, `rtrn_tid_o=1`, one cycle after B.
- Non-cacheable request with `paddr=0x1004` and `AxiDataWidth=64` -> AR `addr=0x1000`, `len=0`. Beat D -> `rtrn_data_o={0,D}`, `rtrn_nc_o=1`.
- `MaxOutstanding=2`, three back-to-back requests with tids 0, 1, 2 -> `req_ready_o` = 0 after the second acceptance. It returns to 1 only after tid 0 is returned, and tags come back in order 0, 1, 2.
- Hold `rtrn_ready_i`=0 for 5 cycles with R beats pending -> `r_ready_o`=0 for those cycles, all `rtrn_*` fields stable, no beats lost.
- With `ICACHE_REFILL_ERR_EN`: second beat carries `r_resp=SLVERR` -> `rtrn_err_o`=1 for that line and 0 for the following clean line. Without the macro -> `rtrn_err_o`=0.
- Assert `rst_ni` low between beats of a burst -> every output takes its reset value immediately, and `pend_cnt`=0 after release.
